mem_stage_mc: RTL and testbench

Parametrised multi-cycle MEM stage for the pipelined processor, successor to the single-cycle MEM stage. It sits between EX and WB. It issues loads and stores to a variable-latency data memory over a req/ack handshake, and supports byte, half, word and (when DW=64) doubleword accesses with byte enables and sign/zero-extended loads. It stalls the upstream pipeline while an access is outstanding and flags misaligned accesses instead of issuing them.

---
 rtl/mem_stage_mc_pkg.sv | 51 +++++
 rtl/mem_stage_mc_if.sv | 36 +++
 rtl/mem_stage_mc_load_align.sv | 56 +++++
 rtl/mem_stage_mc.sv | 202 ++++++++++++++++++++
 tb/tb_mem_stage_mc.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_mc_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the multi-cycle MEM stage and anything that reuses
//   its lane logic (for example, a future data cache).
//   - SZ_B/SZ_H/SZ_W/SZ_D : access size codes carried on mem_size
//   - state_t             : MEM stage FSM states
//   - be_mask()           : byte-enable pattern for a size at a lane offset
//   - is_aligned()        : natural-alignment / legality test for an access
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Offset is always 3 bits wide so one function serves both data widths;
    // a 32-bit bus simply never drives offset[2] or uses the upper four bits.
    function automatic logic [7:0] be_mask(input logic [1:0] size,
                                           input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    // A doubleword access only exists on a 64-bit bus; on a 32-bit bus it is
    // reported the same way as a misaligned access.
    function automatic logic is_aligned(input logic [1:0] size,
                                        input logic [2:0] offset,
                                        input int         dw);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (offset[0] == 1'b0);
            SZ_W:    ok = (offset[1:0] == 2'b00);
            default: ok = (dw == 64) && (offset == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_mc_if.sv
// ---------------------------------------------------------------------------
// mem_stage_mc_if
//   Request/acknowledge data-memory bus between the MEM stage and memory.
//   - req   : access request, held until ack
//   - we    : request is a write
//   - addr  : bus-aligned address
//   - wdata : store data replicated across lanes
//   - be    : byte enables
//   - rdata : read data, valid in the ack cycle
//   - ack   : one-cycle completion pulse
//   Modports: master (MEM stage side), slave (memory side).
// ---------------------------------------------------------------------------
interface mem_stage_mc_if #(
    parameter int DW = 32,
    parameter int AW = 32
);

    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   rdata;
    logic            ack;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack
    );

endinterface

// File: rtl/mem_stage_mc_load_align.sv
// ---------------------------------------------------------------------------
// load_align
//   Purely combinational load lane extractor.
//   - rdata       : full-width word returned by memory
//   - offset      : byte lane where the access starts
//   - size        : SZ_B/SZ_H/SZ_W/SZ_D
//   - is_unsigned : zero-extend instead of sign-extend
//   - data        : the selected lane, right-aligned and extended to DW
// ---------------------------------------------------------------------------
module load_align
    import mem_stage_pkg::*;
#(
    parameter  int DW = 32,
    localparam int OW = $clog2(DW / 8)
) (
    input  logic [DW-1:0] rdata,
    input  logic [OW-1:0] offset,
    input  logic [1:0]    size,
    input  logic          is_unsigned,
    output logic [DW-1:0] data
);

    logic [DW-1:0] lane;
    logic [DW-1:0] keep_mask;
    logic          sign_bit;
    logic          fill;
    int            nbits;

    // Shift the addressed lane down to bit 0, then keep nbits of it and fill
    // everything above with the sign (or zero) bit.
    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (size)
            SZ_B: begin
                nbits    = 8;
                sign_bit = lane[7];
            end
            SZ_H: begin
                nbits    = 16;
                sign_bit = lane[15];
            end
            SZ_W: begin
                nbits    = 32;
                sign_bit = lane[31];
            end
            default: begin
                nbits    = DW;
                sign_bit = lane[DW-1];
            end
        endcase
        fill      = sign_bit & ~is_unsigned;
        keep_mask = ~({DW{1'b1}} << nbits);
        data      = (lane & keep_mask) | (fill ? ~keep_mask : '0);
    end

endmodule

// File: rtl/mem_stage_mc.sv
// ---------------------------------------------------------------------------
// mem_stage_mc
//   Multi-cycle MEM pipeline stage between EX and WB. Issues loads/stores to
//   a variable-latency data memory, stalls upstream while an access is
//   outstanding, and reports misaligned or illegal accesses without issuing.
//   Ports:
//   - clk, rst                  : clock, synchronous active-high reset
//   - in_valid .. mem_unsigned  : EX/MEM slot contents
//   - stall_out                 : upstream must hold its EX/MEM inputs
//   - dmem                      : data-memory bus (master side)
//   - wb_valid .. misalign_err  : registered MEM/WB slot contents
// ---------------------------------------------------------------------------
module mem_stage_mc
    import mem_stage_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int RAW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [AW-1:0]  alu_result_in,
    input  logic [DW-1:0]  store_data_in,
    input  logic [RAW-1:0] reg_wr_addr_in,
    input  logic           reg_wr_en_in,
    input  logic           mem_rd_en,
    input  logic           mem_wr_en,
    input  logic [1:0]     mem_size,
    input  logic           mem_unsigned,
    output logic           stall_out,
    mem_stage_mc_if.master dmem,
    output logic           wb_valid,
    output logic [AW-1:0]  alu_result_out,
    output logic [DW-1:0]  mem_rd_data,
    output logic [RAW-1:0] reg_wr_addr_out,
    output logic           reg_wr_en_out,
    output logic           misalign_err
);

    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);

    state_t         state;

    logic           is_mem;
    logic           legal;
    logic           accept;
    logic [OW-1:0]  in_offset;
    logic [2:0]     in_offset3;
    logic [7:0]     be_full;
    logic [BW-1:0]  be_next;
    logic [DW-1:0]  wdata_next;
    logic [AW-1:0]  addr_next;

    // Request registers drive the bus directly so it stays stable in BUSY.
    logic           req_q;
    logic           we_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [BW-1:0]  be_q;
    logic [1:0]     size_q;
    logic [OW-1:0]  off_q;
    logic           unsigned_q;

    // Fields of the instruction parked in BUSY, delivered to WB on ack.
    logic [AW-1:0]  alu_q;
    logic [RAW-1:0] rd_q;
    logic           wr_en_q;

    logic [DW-1:0]  load_data;

    assign is_mem     = in_valid & (mem_rd_en | mem_wr_en);
    assign in_offset  = alu_result_in[OW-1:0];
    assign in_offset3 = 3'(in_offset);
    assign legal      = is_aligned(mem_size, in_offset3, DW);
    assign accept     = is_mem & legal;
    assign be_full    = be_mask(mem_size, in_offset3);
    assign be_next    = be_full[BW-1:0];
    assign addr_next  = {alu_result_in[AW-1:OW], {OW{1'b0}}};

    // On a 32-bit bus the upper byte-enable bits of the shared mask helper
    // can never be set for a legal access, so they are simply dropped.
    if (BW < 8) begin : g_be_narrow
        logic unused_be_hi;
        assign unused_be_hi = ^be_full[7:BW];
    end

    // Replicate the right-aligned store data across every lane so memory can
    // pick it up wherever the byte enables point.
    always_comb begin
        case (mem_size)
            SZ_B:    wdata_next = {BW{store_data_in[7:0]}};
            SZ_H:    wdata_next = {(DW / 16){store_data_in[15:0]}};
            SZ_W:    wdata_next = {(DW / 32){store_data_in[31:0]}};
            default: wdata_next = store_data_in;
        endcase
    end

    // Stall is combinational: raised in the accept cycle and held through
    // BUSY, but dropped in the ack cycle so the next op can be presented.
    always_comb begin
        stall_out = 1'b0;
        if (state == IDLE) begin
            stall_out = accept;
        end else begin
            stall_out = ~dmem.ack;
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem.be    = be_q;

    load_align #(.DW(DW)) u_load_align (
        .rdata       (dmem.rdata),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data)
    );

    // FSM, request registers and WB output registers. Any stall edge only
    // clears wb_valid; every other WB register holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            be_q            <= '0;
            size_q          <= SZ_B;
            off_q           <= '0;
            unsigned_q      <= 1'b0;
            alu_q           <= '0;
            rd_q            <= '0;
            wr_en_q         <= 1'b0;
            wb_valid        <= 1'b0;
            alu_result_out  <= '0;
            mem_rd_data     <= '0;
            reg_wr_addr_out <= '0;
            reg_wr_en_out   <= 1'b0;
            misalign_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= BUSY;
                        req_q      <= 1'b1;
                        we_q       <= mem_wr_en;
                        addr_q     <= addr_next;
                        wdata_q    <= wdata_next;
                        be_q       <= be_next;
                        size_q     <= mem_size;
                        off_q      <= in_offset;
                        unsigned_q <= mem_unsigned;
                        alu_q      <= alu_result_in;
                        rd_q       <= reg_wr_addr_in;
                        wr_en_q    <= reg_wr_en_in;
                        wb_valid   <= 1'b0;
                    end else if (is_mem) begin
                        wb_valid        <= 1'b1;
                        alu_result_out  <= alu_result_in;
                        mem_rd_data     <= '0;
                        reg_wr_addr_out <= reg_wr_addr_in;
                        reg_wr_en_out   <= 1'b0;
                        misalign_err    <= 1'b1;
                    end else begin
                        wb_valid        <= in_valid;
                        alu_result_out  <= alu_result_in;
                        mem_rd_data     <= '0;
                        reg_wr_addr_out <= reg_wr_addr_in;
                        reg_wr_en_out   <= reg_wr_en_in;
                        misalign_err    <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dmem.ack) begin
                        state           <= IDLE;
                        req_q           <= 1'b0;
                        wb_valid        <= 1'b1;
                        alu_result_out  <= alu_q;
                        mem_rd_data     <= we_q ? '0 : load_data;
                        reg_wr_addr_out <= rd_q;
                        reg_wr_en_out   <= wr_en_q;
                        misalign_err    <= 1'b0;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_mc.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_mc
//   Directed plus randomized bench for mem_stage_mc. Two instances are used:
//   a 32-bit and a 64-bit data bus, sharing the EX/MEM stimulus. Only the
//   instance selected by cur_dw sees in_valid/ack; the other idles.
//   Expected values come from a byte-level model of the access rules.
// ---------------------------------------------------------------------------
module tb_mem_stage_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          cur_dw;
    logic        in_valid;
    logic [31:0] alu_in;
    logic [63:0] sdata;
    logic [4:0]  rd_in;
    logic        wren_in;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  size;
    logic        uns;
    logic        ack;
    logic [63:0] rdata;

    logic        in_valid32;
    logic        in_valid64;
    assign in_valid32 = in_valid && (cur_dw == 32);
    assign in_valid64 = in_valid && (cur_dw == 64);

    mem_stage_mc_if #(.DW(32), .AW(32)) if32 ();
    mem_stage_mc_if #(.DW(64), .AW(32)) if64 ();

    assign if32.ack   = ack && (cur_dw == 32);
    assign if32.rdata = rdata[31:0];
    assign if64.ack   = ack && (cur_dw == 64);
    assign if64.rdata = rdata;

    logic        s32, wbv32, wre32, mis32;
    logic [31:0] alu32, rdd32;
    logic [4:0]  rda32;
    logic        s64, wbv64, wre64, mis64;
    logic [31:0] alu64;
    logic [63:0] rdd64;
    logic [4:0]  rda64;

    mem_stage_mc #(.DW(32), .AW(32), .RAW(5)) dut32 (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid32),
        .alu_result_in   (alu_in),
        .store_data_in   (sdata[31:0]),
        .reg_wr_addr_in  (rd_in),
        .reg_wr_en_in    (wren_in),
        .mem_rd_en       (rd_en),
        .mem_wr_en       (wr_en),
        .mem_size        (size),
        .mem_unsigned    (uns),
        .stall_out       (s32),
        .dmem            (if32),
        .wb_valid        (wbv32),
        .alu_result_out  (alu32),
        .mem_rd_data     (rdd32),
        .reg_wr_addr_out (rda32),
        .reg_wr_en_out   (wre32),
        .misalign_err    (mis32)
    );

    mem_stage_mc #(.DW(64), .AW(32), .RAW(5)) dut64 (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid64),
        .alu_result_in   (alu_in),
        .store_data_in   (sdata),
        .reg_wr_addr_in  (rd_in),
        .reg_wr_en_in    (wren_in),
        .mem_rd_en       (rd_en),
        .mem_wr_en       (wr_en),
        .mem_size        (size),
        .mem_unsigned    (uns),
        .stall_out       (s64),
        .dmem            (if64),
        .wb_valid        (wbv64),
        .alu_result_out  (alu64),
        .mem_rd_data     (rdd64),
        .reg_wr_addr_out (rda64),
        .reg_wr_en_out   (wre64),
        .misalign_err    (mis64)
    );

    // Observation view of whichever instance is under test.
    logic [63:0] o_stall, o_req, o_we, o_addr, o_wdata, o_be;
    logic [63:0] o_wbv, o_alu, o_rdd, o_rda, o_wre, o_mis;

    always_comb begin
        if (cur_dw == 64) begin
            o_stall = 64'(s64);
            o_req   = 64'(if64.req);
            o_we    = 64'(if64.we);
            o_addr  = 64'(if64.addr);
            o_wdata = if64.wdata;
            o_be    = 64'(if64.be);
            o_wbv   = 64'(wbv64);
            o_alu   = 64'(alu64);
            o_rdd   = rdd64;
            o_rda   = 64'(rda64);
            o_wre   = 64'(wre64);
            o_mis   = 64'(mis64);
        end else begin
            o_stall = 64'(s32);
            o_req   = 64'(if32.req);
            o_we    = 64'(if32.we);
            o_addr  = 64'(if32.addr);
            o_wdata = 64'(if32.wdata);
            o_be    = 64'(if32.be);
            o_wbv   = 64'(wbv32);
            o_alu   = 64'(alu32);
            o_rdd   = 64'(rdd32);
            o_rda   = 64'(rda32);
            o_wre   = 64'(wre32);
            o_mis   = 64'(mis32);
        end
    end

    int checks;
    int passes;

    // Last WB contents the model expects, used to verify holding on stalls.
    logic [63:0] exp_alu, exp_rd, exp_wren, exp_mis, exp_rdd;
    bit          rdd_known;

    // Access-rule model: sizes are byte counts, lanes are byte positions.
    function automatic bit m_legal(input int sz, input logic [31:0] addr, input int dw);
        int nbytes;
        nbytes = 1 << sz;
        if (nbytes * 8 > dw) return 1'b0;
        return (int'(addr[2:0]) % nbytes) == 0;
    endfunction

    function automatic logic [63:0] m_be(input int sz, input int off);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < (1 << sz); i++) m = m | (64'd1 << (off + i));
        return m;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] data, input int sz, input int dw);
        logic [63:0] r;
        int          nb;
        r  = 64'd0;
        nb = 1 << sz;
        for (int j = 0; j < dw / 8; j++)
            r = r | (((data >> (8 * (j % nb))) & 64'hFF) << (8 * j));
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input int off,
                                           input int sz, input bit u, input int dw);
        logic [63:0] v;
        int          nb;
        v  = 64'd0;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++)
            v = v | (((rd >> (8 * (off + i))) & 64'hFF) << (8 * i));
        if (!u && (((v >> (8 * nb - 1)) & 64'd1) != 64'd0))
            for (int i = nb; i < dw / 8; i++) v = v | (64'hFF << (8 * i));
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (dw=%0d)", tag, obs, exp, cur_dw);
    endtask

    task automatic driveIdle();
        in_valid = 1'b0;
        alu_in   = 32'd0;
        sdata    = 64'd0;
        rd_in    = 5'd0;
        wren_in  = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        size     = 2'd0;
        uns      = 1'b0;
    endtask

    task automatic clearModel();
        exp_alu   = 64'd0;
        exp_rd    = 64'd0;
        exp_wren  = 64'd0;
        exp_mis   = 64'd0;
        exp_rdd   = 64'd0;
        rdd_known = 1'b1;
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_stall"}, o_stall, 64'd0);
        checkOutput({tag, "_req"},   o_req,   64'd0);
        checkOutput({tag, "_wbv"},   o_wbv,   64'd0);
        checkOutput({tag, "_alu"},   o_alu,   64'd0);
        checkOutput({tag, "_rdd"},   o_rdd,   64'd0);
        checkOutput({tag, "_rda"},   o_rda,   64'd0);
        checkOutput({tag, "_wre"},   o_wre,   64'd0);
        checkOutput({tag, "_mis"},   o_mis,   64'd0);
    endtask

    // One idle cycle with zeroed inputs; optionally pulses a stray ack.
    task automatic idleCycle(input bit pulse_ack);
        driveIdle();
        ack = pulse_ack;
        #1;
        checkOutput("idle_stall", o_stall, 64'd0);
        @(posedge clk);
        #1;
        ack = 1'b0;
        checkOutput("idle_req", o_req, 64'd0);
        checkOutput("idle_wbv", o_wbv, 64'd0);
        checkOutput("idle_stall_after", o_stall, 64'd0);
        checkOutput("idle_alu", o_alu, 64'd0);
        checkOutput("idle_mis", o_mis, 64'd0);
        clearModel();
    endtask

    // One instruction: kind 0 = ALU op, 1 = load, 2 = store. Aligned memory
    // ops see ack in BUSY cycle 'lat'. Called at posedge+1.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [63:0] data,
                                 input int sz, input bit u, input logic [4:0] rdaddr,
                                 input bit wren, input int lat, input logic [63:0] rdat);
        bit          is_mem;
        bit          legal;
        int          off;
        logic [31:0] ea;
        is_mem = (kind != 0);
        legal  = is_mem && m_legal(sz, addr, cur_dw);
        off    = int'(addr[2:0]) % (cur_dw / 8);
        ea     = addr - 32'(off);

        in_valid = 1'b1;
        alu_in   = addr;
        sdata    = data;
        rd_in    = rdaddr;
        wren_in  = wren;
        rd_en    = (kind == 1);
        wr_en    = (kind == 2);
        size     = sz[1:0];
        uns      = u;
        #1;
        checkOutput("accept_stall", o_stall, 64'(legal));

        if (!legal) begin
            @(posedge clk);
            #1;
            driveIdle();
            checkOutput("direct_wbv",  o_wbv, 64'd1);
            checkOutput("direct_mis",  o_mis, 64'(is_mem));
            checkOutput("direct_wre",  o_wre, is_mem ? 64'd0 : 64'(wren));
            checkOutput("direct_alu",  o_alu, 64'(addr));
            checkOutput("direct_rda",  o_rda, 64'(rdaddr));
            checkOutput("direct_req",  o_req, 64'd0);
            exp_alu   = 64'(addr);
            exp_rd    = 64'(rdaddr);
            exp_wren  = is_mem ? 64'd0 : 64'(wren);
            exp_mis   = 64'(is_mem);
            rdd_known = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            for (int i = 1; i <= lat; i++) begin
                checkOutput("busy_req",  o_req,  64'd1);
                checkOutput("busy_addr", o_addr, 64'(ea));
                checkOutput("busy_be",   o_be,   m_be(sz, off));
                checkOutput("busy_we",   o_we,   64'(kind == 2));
                if (kind == 2) checkOutput("busy_wdata", o_wdata, m_wdata(data, sz, cur_dw));
                checkOutput("busy_wbv",  o_wbv,  64'd0);
                checkOutput("hold_alu",  o_alu,  exp_alu);
                checkOutput("hold_rda",  o_rda,  exp_rd);
                checkOutput("hold_wre",  o_wre,  exp_wren);
                checkOutput("hold_mis",  o_mis,  exp_mis);
                if (rdd_known) checkOutput("hold_rdd", o_rdd, exp_rdd);
                if (i == lat) begin
                    ack   = 1'b1;
                    rdata = rdat;
                end
                #1;
                checkOutput("busy_stall", o_stall, (i == lat) ? 64'd0 : 64'd1);
                @(posedge clk);
                #1;
                ack   = 1'b0;
                rdata = {$urandom, $urandom};
            end
            driveIdle();
            exp_alu   = 64'(addr);
            exp_rd    = 64'(rdaddr);
            exp_wren  = 64'(wren);
            exp_mis   = 64'd0;
            exp_rdd   = (kind == 1) ? m_load(rdat, off, sz, u, cur_dw) : 64'd0;
            rdd_known = 1'b1;
            checkOutput("wb_wbv", o_wbv, 64'd1);
            checkOutput("wb_alu", o_alu, exp_alu);
            checkOutput("wb_rda", o_rda, exp_rd);
            checkOutput("wb_wre", o_wre, exp_wren);
            checkOutput("wb_mis", o_mis, 64'd0);
            checkOutput("wb_rdd", o_rdd, exp_rdd);
            checkOutput("wb_req", o_req, 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int          r_kind;
    int          r_sz;
    int          r_lat;
    logic [31:0] r_addr;

    initial begin
        checks = 0;
        passes = 0;
        cur_dw = 32;
        rst    = 1'b1;
        ack    = 1'b0;
        rdata  = 64'd0;
        driveIdle();
        clearModel();

        repeat (3) @(posedge clk);
        #1;
        checkZero("reset32");
        cur_dw = 64;
        #1;
        checkZero("reset64");
        cur_dw = 32;
        #1;
        rst = 1'b0;

        // ADD: plain result forwarded in one cycle, then a stray ack in IDLE.
        applyStimulus(0, 32'h1234, 64'd0, 2, 1'b0, 5'd7, 1'b1, 1, 64'd0);
        idleCycle(1'b1);

        // LB signed from the top lane, ack in the second BUSY cycle.
        applyStimulus(1, 32'h103, 64'd0, 0, 1'b0, 5'd5, 1'b1, 2, 64'h0000_0000_8000_0000);
        checkOutput("lb_const", o_rdd, 64'hFFFF_FF80);

        // SB with a three-cycle memory.
        applyStimulus(2, 32'h102, 64'hAB, 0, 1'b0, 5'd0, 1'b0, 3, 64'd0);

        // Misaligned LW and illegal doubleword on a 32-bit bus.
        applyStimulus(1, 32'h302, 64'd0, 2, 1'b0, 5'd9, 1'b1, 1, 64'd0);
        applyStimulus(1, 32'h408, 64'd0, 3, 1'b0, 5'd10, 1'b1, 1, 64'd0);

        // Back-to-back aligned ops with no idle cycle between them.
        applyStimulus(1, 32'h400, 64'd0, 2, 1'b0, 5'd3, 1'b1, 1, 64'h0000_0000_CAFE_F00D);
        applyStimulus(2, 32'h404, 64'hDEAD_BEEF, 2, 1'b0, 5'd0, 1'b0, 1, 64'd0);
        applyStimulus(1, 32'h406, 64'd0, 1, 1'b1, 5'd4, 1'b1, 1, 64'h0000_0000_9123_4567);

        // Reset during the second BUSY cycle, then a late ack.
        in_valid = 1'b1;
        alu_in   = 32'h500;
        rd_in    = 5'd6;
        wren_in  = 1'b1;
        rd_en    = 1'b1;
        size     = 2'd2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        driveIdle();
        ack = 1'b1;
        #1;
        checkZero("rst_busy");
        @(posedge clk);
        #1;
        ack = 1'b0;
        checkZero("late_ack");
        clearModel();

        // Randomized traffic on the 32-bit instance.
        for (int n = 0; n < 40; n++) begin
            r_kind = int'($urandom_range(0, 2));
            r_sz   = int'($urandom_range(0, 3));
            r_lat  = int'($urandom_range(1, 4));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << r_sz) - 32'd1);
            applyStimulus(r_kind, r_addr, {$urandom, $urandom}, r_sz, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), r_lat,
                          {$urandom, $urandom});
        end

        // 64-bit instance.
        cur_dw = 64;
        idleCycle(1'b0);
        applyStimulus(1, 32'h206, 64'd0, 1, 1'b1, 5'd4, 1'b1, 1, 64'hBEEF_0000_0000_0000);
        checkOutput("lhu64_const", o_rdd, 64'h0000_0000_0000_BEEF);
        applyStimulus(2, 32'h208, 64'h0123_4567_89AB_CDEF, 3, 1'b0, 5'd0, 1'b0, 2, 64'd0);
        applyStimulus(1, 32'h204, 64'd0, 3, 1'b0, 5'd11, 1'b1, 1, 64'd0);
        applyStimulus(1, 32'h217, 64'd0, 0, 1'b0, 5'd12, 1'b1, 1, 64'h8000_0000_0000_0000);
        applyStimulus(1, 32'h210, 64'd0, 3, 1'b0, 5'd13, 1'b1, 3, 64'hFEDC_BA98_7654_3210);

        for (int n = 0; n < 25; n++) begin
            r_kind = int'($urandom_range(0, 2));
            r_sz   = int'($urandom_range(0, 3));
            r_lat  = int'($urandom_range(1, 4));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << r_sz) - 32'd1);
            applyStimulus(r_kind, r_addr, {$urandom, $urandom}, r_sz, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), r_lat,
                          {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
